// File: rtl/keyboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_pkg
// Description : Shared encodings for the 4x4 keypad scanner. These are the
//               FSM states, the column drive patterns, the key codes and the
//               default debounce length.
// Revision    : 1.0 - initial release
// ============================================================================
package keyboard_pkg;

  // Scanner FSM states (3-bit encoding visible on the debug port)
  typedef enum logic [2:0] {
    S0_IDLE    = 3'd0,
    S1_SCAN0   = 3'd1,
    S2_SCAN1   = 3'd2,
    S3_SCAN2   = 3'd3,
    S4_SCAN3   = 3'd4,
    S5_PRESSED = 3'd5
  } state_t;

  // Column drive patterns (active-low)
  localparam logic [3:0] COL_IDLE  = 4'b0000;
  localparam logic [3:0] COL_SCAN0 = 4'b1110;
  localparam logic [3:0] COL_SCAN1 = 4'b1101;
  localparam logic [3:0] COL_SCAN2 = 4'b1011;
  localparam logic [3:0] COL_SCAN3 = 4'b0111;

  // Key codes: digits use their own value so they can be forwarded directly
  localparam logic [3:0] KEY_0       = 4'd0;
  localparam logic [3:0] KEY_1       = 4'd1;
  localparam logic [3:0] KEY_2       = 4'd2;
  localparam logic [3:0] KEY_3       = 4'd3;
  localparam logic [3:0] KEY_4       = 4'd4;
  localparam logic [3:0] KEY_5       = 4'd5;
  localparam logic [3:0] KEY_6       = 4'd6;
  localparam logic [3:0] KEY_7       = 4'd7;
  localparam logic [3:0] KEY_8       = 4'd8;
  localparam logic [3:0] KEY_9       = 4'd9;
  localparam logic [3:0] KEY_START   = 4'd10;
  localparam logic [3:0] KEY_CLEAR   = 4'd11;
  localparam logic [3:0] KEY_CONFIRM = 4'd12;
  localparam logic [3:0] KEY_NONE    = 4'd15;

  // Stable-press cycles before acceptance (20 ms at 1 kHz)
  localparam int DEBOUNCE_DEFAULT = 20;

  // True when the key code is a digit 0..9
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= KEY_9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_decoder
// Description : Combinational map from the latched row/column codes
//               (active-low) to a key code. When several rows are low, the
//               lowest-index row wins.
// Revision    : 1.0 - initial release
// ============================================================================
module key_decoder
  import keyboard_pkg::*;
(
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output logic [3:0] key_o
);

  logic [1:0] w_row_idx;
  logic [1:0] w_col_idx;
  logic       w_row_any;
  logic       w_col_any;

  // Priority-encode the lowest-index low row and column
  always_comb begin
    w_row_idx = 2'd0;
    w_row_any = 1'b0;
    w_col_idx = 2'd0;
    w_col_any = 1'b0;
    // Descending scan so the lowest low index is the last one written
    for (int i = 3; i >= 0; i--) begin
      if (!row_i[i]) begin
        w_row_idx = 2'(i);
        w_row_any = 1'b1;
      end
      if (!col_i[i]) begin
        w_col_idx = 2'(i);
        w_col_any = 1'b1;
      end
    end
  end

  // Keypad layout lookup indexed by {row index, column index}
  always_comb begin
    key_o = KEY_NONE;
    if (w_row_any && w_col_any) begin
      case ({w_row_idx, w_col_idx})
        4'b11_11: key_o = KEY_1;
        4'b11_10: key_o = KEY_2;
        4'b11_01: key_o = KEY_3;
        4'b11_00: key_o = KEY_4;
        4'b10_11: key_o = KEY_5;
        4'b10_10: key_o = KEY_6;
        4'b10_01: key_o = KEY_7;
        4'b10_00: key_o = KEY_8;
        4'b01_11: key_o = KEY_9;
        4'b01_10: key_o = KEY_0;
        4'b00_11: key_o = KEY_START;
        4'b00_10: key_o = KEY_CLEAR;
        4'b00_01: key_o = KEY_CONFIRM;
        default:  key_o = KEY_NONE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/keyboard_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_scanner
// Description : 4x4 active-low keypad scanner with debounce. It emits one
//               single-cycle pulse per accepted press: a digit (press_num +
//               key_value), start, clear or confirm.
//               Define KEYBOARD_DEBUG_EN to expose current_state, next_state
//               and cnt. Otherwise those ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module keyboard_scanner
  import keyboard_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT  // 1..63
)
(
  input  logic       clk,
  input  logic       rst_n,          // active-high despite the name
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       press_num,
  output logic       start,
  output logic       clear,
  output logic       confirm,
  output logic [2:0] current_state,
  output logic [2:0] next_state,
  output logic [5:0] cnt
);

  localparam logic [5:0] CNT_LAST = 6'(DEBOUNCE - 1);
  localparam logic [5:0] CNT_MAX  = 6'(DEBOUNCE);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] col_q;
  logic [3:0] row_lat_q;
  logic [5:0] cnt_q;
  logic [3:0] key_value_q;
  logic       press_num_q;
  logic       start_q;
  logic       clear_q;
  logic       confirm_q;

  logic       w_row_active;
  logic       w_row_match;
  logic       w_accept;
  logic [3:0] w_key_code;

  assign w_row_active = ~&row;
  assign w_row_match  = (row == row_lat_q);
  // Acceptance fires in the last debounce cycle. The pulse register then
  // shows it DEBOUNCE cycles after S5 entry.
  assign w_accept     = (state_q == S5_PRESSED) && w_row_match && (cnt_q == CNT_LAST);

  // While in S5, col_q holds the latched column
  key_decoder u_key_decoder (
    .row_i (row_lat_q),
    .col_i (col_q),
    .key_o (w_key_code)
  );

  // Next-state selection: scan the columns, then stay in S5 while the row is stable
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0_IDLE:    if (w_row_active) state_d = S1_SCAN0;
      S1_SCAN0:   state_d = w_row_active ? S5_PRESSED : S2_SCAN1;
      S2_SCAN1:   state_d = w_row_active ? S5_PRESSED : S3_SCAN2;
      S3_SCAN2:   state_d = w_row_active ? S5_PRESSED : S4_SCAN3;
      S4_SCAN3:   state_d = w_row_active ? S5_PRESSED : S0_IDLE;
      // Release or a change to another row code both abandon the press
      S5_PRESSED: if (!w_row_match) state_d = S0_IDLE;
      default:    state_d = S0_IDLE;
    endcase
  end

  // State register, registered column drive, debounce counter and output pulses
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S0_IDLE;
      col_q       <= COL_IDLE;
      row_lat_q   <= 4'b1111;
      cnt_q       <= 6'd0;
      key_value_q <= 4'd0;
      press_num_q <= 1'b0;
      start_q     <= 1'b0;
      clear_q     <= 1'b0;
      confirm_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_num_q <= 1'b0;
      start_q     <= 1'b0;
      clear_q     <= 1'b0;
      confirm_q   <= 1'b0;

      // Column follows the upcoming state so col and state change together
      case (state_d)
        S0_IDLE:  col_q <= COL_IDLE;
        S1_SCAN0: col_q <= COL_SCAN0;
        S2_SCAN1: col_q <= COL_SCAN1;
        S3_SCAN2: col_q <= COL_SCAN2;
        S4_SCAN3: col_q <= COL_SCAN3;
        default:  col_q <= col_q;   // S5 keeps the column that found the key
      endcase

      if ((state_q != S5_PRESSED) && (state_d == S5_PRESSED)) begin
        row_lat_q <= row;
      end

      // Count stable cycles in S5 and saturate so a held key never repeats
      if ((state_q == S5_PRESSED) && (state_d == S5_PRESSED)) begin
        if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + 6'd1;
        end
      end else begin
        cnt_q <= 6'd0;
      end

      if (w_accept) begin
        if (is_digit(w_key_code)) begin
          press_num_q <= 1'b1;
          key_value_q <= w_key_code;
        end else begin
          case (w_key_code)
            KEY_START:   start_q   <= 1'b1;
            KEY_CLEAR:   clear_q   <= 1'b1;
            KEY_CONFIRM: confirm_q <= 1'b1;
            default:     ;            // no-op key: debounced but silent
          endcase
        end
      end
    end
  end

  assign col       = col_q;
  assign key_value = key_value_q;
  assign press_num = press_num_q;
  assign start     = start_q;
  assign clear     = clear_q;
  assign confirm   = confirm_q;

`ifdef KEYBOARD_DEBUG_EN
  assign current_state = state_q;
  assign next_state    = state_d;
  assign cnt           = cnt_q;
`else
  assign current_state = 3'd0;
  assign next_state    = 3'd0;
  assign cnt           = 6'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keyboard_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keyboard_scanner
// Description : Scoreboard bench for keyboard_scanner. A keypad model drives
//               the rows from the DUT columns. Expected pulses are queued at
//               press time and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keyboard_scanner;

  localparam int DEB = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_value;
  logic       press_num;
  logic       start;
  logic       clear;
  logic       confirm;
  logic [2:0] current_state;
  logic [2:0] next_state;
  logic [5:0] cnt;

  logic [15:0] pressed;   // bit r*4+c: key at (row r, col c) held down
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errs = 0;
  int          last_digit;
  bit          done;

  typedef struct {
    int code;   // 0..9 digit, 10 start, 11 clear, 12 confirm
    int at;     // cycle at which the pulse is expected
    int kv;     // key_value expected during the pulse
  } exp_t;
  exp_t exp_q[$];

  keyboard_scanner #(.DEBOUNCE(DEB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .row           (row),
    .col           (col),
    .key_value     (key_value),
    .press_num     (press_num),
    .start         (start),
    .clear         (clear),
    .confirm       (confirm),
    .current_state (current_state),
    .next_state    (next_state),
    .cnt           (cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive keypad: a row is pulled low when a held key sits on a driven column
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r*4 +: 4] & ~col);
  end

  // Key legend: -1 means the key does nothing
  function automatic int key_code(input int r, input int c);
    case (r)
      3: return 4 - c;
      2: return 8 - c;
      1: return (c == 3) ? 9 : (c == 2) ? 0 : -1;
      default: return (c == 3) ? 10 : (c == 2) ? 11 : (c == 1) ? 12 : -1;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Press a set of keys sharing first-scanned column c. The DUT is idle
  // before the press. S5 is reached c+2 edges after the press, and the
  // pulse comes DEB edges later, provided the keys are still held by then.
  task automatic press_mask(input logic [15:0] mask, input int c, input int code,
                            input int hold, input int gap);
    int t0;
    @(posedge clk);
    #1;
    pressed = mask;
    t0 = cyc;
    if (code >= 0 && hold >= c + 2 + DEB) begin
      if (code <= 9) last_digit = code;
      exp_q.push_back('{code: code, at: t0 + c + 2 + DEB, kv: last_digit});
    end
    repeat (hold) @(posedge clk);
    #1 pressed = '0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic press_key(input int r, input int c, input int hold, input int gap);
    press_mask(16'd1 << (r * 4 + c), c, key_code(r, c), hold, gap);
  endtask

  initial begin
    pressed    = '0;
    last_digit = 0;
    done       = 1'b0;
    fork
      begin : g_stimulus
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_col", int'(col), 0);
        check("reset_key_value", int'(key_value), 0);
        check("reset_pulses", int'({press_num, start, clear, confirm}), 0);
        check("reset_current_state", int'(current_state), 0);
        check("reset_next_state", int'(next_state), 0);
        check("reset_cnt", int'(cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (6) @(posedge clk);

        press_key(3, 0, 100, 8);           // digit 4
        press_key(3, 0, 10, 8);            // glitch, no pulse
        @(negedge clk);
        check("glitch_key_value_hold", int'(key_value), 4);
        press_key(3, 2, 4000, 8);          // held digit 2, single pulse
        press_key(0, 2, 50, 8);            // clear, key_value stays 2

        // Reset in the middle of the debounce of key (3,1)
        @(posedge clk);
        #1 pressed = 16'd1 << 13;
        repeat (13) @(posedge clk);
        @(negedge clk);                    // 10 cycles into S5
`ifdef KEYBOARD_DEBUG_EN
        check("dbg_state_s5", int'(current_state), 5);
        check("dbg_next_s5", int'(next_state), 5);
        check("dbg_cnt_s5", int'(cnt), 10);
`else
        check("dbg_state_tied", int'(current_state), 0);
        check("dbg_next_tied", int'(next_state), 0);
        check("dbg_cnt_tied", int'(cnt), 0);
`endif
        #1 rst_n = 1'b1;
        #1;
        check("midpress_reset_col", int'(col), 0);
        check("midpress_reset_cnt", int'(cnt), 0);
        check("midpress_reset_key_value", int'(key_value), 0);
        check("midpress_reset_pulses", int'({press_num, start, clear, confirm}), 0);
        last_digit = 0;
        pressed = '0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (6) @(posedge clk);

        press_key(3, 1, 60, 8);            // fresh press: digit 3
        press_key(0, 0, 50, 8);            // no-op key
        press_key(1, 3, 3 + 2 + DEB, 8);   // release on the pulse cycle: 9
        press_key(1, 2, 2 + 1 + DEB, 8);   // one cycle short: nothing
        press_mask((16'd1 << 7) | (16'd1 << 15), 3, 9, 60, 8);  // rows 1 and 3: row 1 wins
        press_key(0, 3, 40, 8);            // start
        press_key(0, 1, 40, 8);            // confirm

        for (int i = 0; i < 30; i++) begin
          int r;
          int c;
          int h;
          r = int'($urandom_range(0, 3));
          c = int'($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) h = c + 2 + DEB + int'($urandom_range(0, 30));
          else                           h = int'($urandom_range(1, c + 1 + DEB));
          press_key(r, c, h, int'($urandom_range(6, 12)));
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("final_key_value", int'(key_value), last_digit);
        done = 1'b1;
      end
      begin : g_monitor
        while (!done) begin
          int   act;
          exp_t e;
          @(negedge clk);
          if (press_num | start | clear | confirm) begin
            if ($countones({press_num, start, clear, confirm}) != 1) act = -2;
            else if (press_num) act = int'(key_value);
            else if (start)     act = 10;
            else if (clear)     act = 11;
            else                act = 12;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errs++;
              $display("FAIL unexpected_pulse: got code %0d at cycle %0d, expected no pulse", act, cyc);
            end else begin
              e = exp_q.pop_front();
              check("pulse_code", act, e.code);
              check("pulse_cycle", cyc, e.at);
              check("pulse_key_value", int'(key_value), e.kv);
            end
          end
        end
      end
    join
    check("pending_pulses", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keyboard_scanner.md
# keyboard_scanner

Scans a 4×4 active-low matrix keypad and debounces key presses. It decodes each press into a digit or command and emits one single-cycle pulse per press. It sits between the keypad pins and the charger control FSM, which consumes digit entries (`press_num`/`key_value`) and the `start`, `clear` and `confirm` commands. It runs from the 1 kHz system clock, so one cycle is 1 ms.

## Interface
- `DEBOUNCE`, 20: stable-press cycles required before a key is accepted (20 ms at 1 kHz); 1..63.
- `clk`  in  1  system clock (1 kHz), rising edge.
- `rst_n`  in  1  asynchronous active-high reset: asserted when 1. The port name is kept for codebase consistency.
- `row`  in  4  keypad rows, active-low; `1111` = no key.
- `col`  out  4  column drive, active-low.
- `key_value`  out  4  last accepted digit, 0–9.
- `press_num`  out  1  1-cycle pulse: digit accepted; `key_value` is valid in the same cycle.
- `start`  out  1  1-cycle pulse: start key accepted.
- `clear`  out  1  1-cycle pulse: clear key accepted.
- `confirm`  out  1  1-cycle pulse: confirm key accepted.
- `current_state`  out  3  FSM state (debug).
- `next_state`  out  3  combinational next state (debug).
- `cnt`  out  6  debounce counter (debug).

## Operation
- States, 3-bit encoding:
  - S0 IDLE = 0: `col=0000`; any row low → S1.
  - S1..S4 = 1..4: scan states; `col` = 1110, 1101, 1011, 0111 respectively (col[0]..col[3] low).
  - S5 PRESSED = 5.
- In S1..S4:
  - Any row low → S5, latching the row and column codes.
  - Otherwise advance to the next scan state; S4 with no row low → S0.
- In S5:
  - `col` holds the latched column.
  - `cnt` increments while `row` equals the latched row, saturating at `DEBOUNCE`.
  - When `cnt` reaches `DEBOUNCE-1`, emit exactly one output pulse.
  - `row==1111` → S0 and `cnt` is cleared.
  - A `row` change to a different non-idle code → S0; no pulse.
- Key map, indexed by (low row, low col):
  - row[3]: col3..col0 = 1, 2, 3, 4.
  - row[2]: col3..col0 = 5, 6, 7, 8.
  - row[1]: col3 = 9, col2 = 0; col1 and col0 are no-op.
  - row[0]: col3 = start, col2 = clear, col1 = confirm; col0 is no-op.
- Multiple rows low at once: the lowest-index low row wins.
- A no-op key runs the full debounce but emits nothing.
- `key_value` updates only on a digit acceptance and otherwise holds.
- Holding a key emits a single pulse. There is no auto-repeat; the next pulse requires release (return to S0).
- Reset, asynchronous and including mid-press:
  - State = S0, `cnt=0`, `col=0000`.
  - `key_value=0`; all pulses 0.
  - `next_state` = the combinational value for S0.

## Timing
- All outputs are registered, except `next_state`.
- Row goes low in S0 → S1 on the next edge. The matching column is reached within at most 4 further cycles.
- Pulse latency: the pulse is asserted `DEBOUNCE` cycles after entering S5 (S5 entry = cycle 0, pulse in cycle `DEBOUNCE`). It lasts exactly 1 cycle.
- A glitch shorter than `DEBOUNCE` cycles reaches S5 but produces no pulse, e.g. 10 ms at the default.
- Release during the pulse cycle: the pulse still completes.

## Configuration
- `KEYBOARD_DEBUG_EN` defined: `current_state`, `next_state` and `cnt` drive their internal values.
- `KEYBOARD_DEBUG_EN` undefined: the ports remain but are tied to 0. Functional outputs are identical in both builds.

## Structure
- Package `keyboard_pkg` holds:
  - the state encoding constants S0–S5;
  - the key-code constants (digits 0–9, start, clear, confirm, none);
  - the default `DEBOUNCE`.
- One sub-module, `key_decoder`: combinational (latched row, latched col) → key code, per the key map.

## Test plan
- Bench drives `row` combinationally from `col`.
- Press key (row `0111`, col `1110`) for 100 ms, then release → one `press_num` pulse, `key_value=4`, back to S0.
- Same key for 10 ms → reaches S5, no pulse, returns to S0; `key_value` still 4.
- Hold row `0111` at col `1011` for 4 s → exactly one `press_num`, `key_value=2`; no repeat until release.
- Press row `1110`, col `1011` for 50 ms → one `clear` pulse; `key_value` unchanged (2).
- Assert reset while in S5 mid-debounce → immediately S0, `col=0000`, `cnt=0`, no pulse. After release, a fresh press behaves normally.
- Press row `1110`, col `1110` (no-op key) → no pulse on any output.
